// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 device-side transmitter.
//   ps2_state_e    - transmitter FSM states
//   PS2_FRAME_BITS - start + 8 data + parity + stop
//   ps2_parity()   - odd-parity bit for a data byte
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        StIdle,
        StBitHi,
        StBitLo,
        StGap
    } ps2_state_e;

    // Odd parity: the parity bit makes the total count of ones in data+parity odd.
    function automatic logic ps2_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_tick_gen.sv
// ps2_tick_gen: half-period down-counter for the PS/2 clock.
//   clk_sys  in  system clock
//   rst      in  asynchronous active-high reset
//   i_load   in  reload the counter with CLK_DIV-1 (start of a new phase)
//   o_expire out last cycle of the current half-period
module ps2_tick_gen
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2500
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic i_load,
    output logic o_expire
);

    localparam logic [15:0] LOAD_VAL = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: sends one byte at a time as an 11-bit PS/2 device-to-host frame
// (start, D0..D7, odd parity, stop), driving both lines itself, followed by an
// idle gap of GAP_CYC cycles.
//   clk_sys      in  system clock
//   rst          in  asynchronous active-high reset
//   tx_data      in  byte to send
//   tx_valid     in  byte offered, held until accepted
//   tx_ready     out byte can be accepted this cycle
//   ps2_clk_out  out PS/2 clock drive level (1 = released)
//   ps2_data_out out PS/2 data drive level (1 = released)
//   ps2_clk_in   in  sampled PS/2 clock line (host inhibit detection)
//   busy         out frame or gap in progress
//   tx_done      out one-cycle pulse when the stop bit completes
// Optional feature macro: PS2_TX_INHIBIT_EN (host inhibit / abort-and-retry).
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2500,
    parameter int unsigned GAP_CYC = 5000
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    input  logic       ps2_clk_in,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned GAP_W     = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                r_state, w_state_nxt;
    logic [3:0]                r_bit, w_bit_nxt;
    logic [PS2_FRAME_BITS-1:0] r_frame, w_frame_nxt;
    logic [GAP_W-1:0]          r_gap, w_gap_nxt;
    logic                      r_done, w_done_nxt;
    logic                      w_load;
    logic                      w_expire;
    logic                      w_ready;

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] r_sync;
    logic       r_retry, w_retry_nxt;
    logic       w_inhibit;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], ps2_clk_in};
        end
    end

    assign w_inhibit = ~r_sync[1];
    assign w_ready   = (r_state == StIdle) && !w_inhibit;
`else
    logic w_unused_clk_in;
    assign w_unused_clk_in = ps2_clk_in;
    assign w_ready         = (r_state == StIdle);
`endif

    ps2_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .i_load   (w_load),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_frame_nxt = r_frame;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
`ifdef PS2_TX_INHIBIT_EN
        w_retry_nxt = r_retry;
`endif
        case (r_state)
            StIdle: begin
                if (tx_valid && w_ready) begin
                    w_frame_nxt = {1'b1, ps2_parity(tx_data), tx_data, 1'b0};
                    w_bit_nxt   = '0;
                    w_state_nxt = StBitHi;
                    w_load      = 1'b1;
                end
            end
            StBitHi: begin
                if (w_expire) begin
                    w_state_nxt = StBitLo;
                    w_load      = 1'b1;
                end
`ifdef PS2_TX_INHIBIT_EN
                // Host pulled clock low: abandon this attempt and retry after the gap.
                // Once the stop bit is on the line the frame is allowed to finish.
                if (w_inhibit && (r_bit < LAST_BIT)) begin
                    w_state_nxt = StGap;
                    w_load      = 1'b0;
                    w_gap_nxt   = GAP_LOAD;
                    w_bit_nxt   = '0;
                    w_retry_nxt = 1'b1;
                end
`endif
            end
            StBitLo: begin
                if (w_expire) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = StGap;
                        w_gap_nxt   = GAP_LOAD;
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = StBitHi;
                        w_bit_nxt   = r_bit + 4'd1;
                        w_load      = 1'b1;
                    end
                end
            end
            StGap: begin
                if (r_gap == '0) begin
                    w_state_nxt = StIdle;
`ifdef PS2_TX_INHIBIT_EN
                    if (r_retry) begin
                        // Frame register still holds the aborted byte.
                        w_state_nxt = StBitHi;
                        w_bit_nxt   = '0;
                        w_load      = 1'b1;
                        w_retry_nxt = 1'b0;
                    end
`endif
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_bit   <= '0;
            r_frame <= '1;
            r_gap   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_frame <= w_frame_nxt;
            r_gap   <= w_gap_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef PS2_TX_INHIBIT_EN
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_retry <= 1'b0;
        end else begin
            r_retry <= w_retry_nxt;
        end
    end
`endif

    // Bit value is presented for the whole BIT_HI/BIT_LO pair; r_bit only
    // changes on the BIT_LO -> BIT_HI edge, so data is stable while clock is low.
    assign ps2_data_out = ((r_state == StBitHi) || (r_state == StBitLo)) ? r_frame[r_bit] : 1'b1;
    assign ps2_clk_out  = (r_state != StBitLo);
    assign tx_ready     = w_ready;
    assign busy         = (r_state != StIdle);
    assign tx_done      = r_done;

endmodule
